// File: rtl/loop_count_if.sv
// Handshake and datapath bundle between the loop-count controller and its
// surrounding datapath (start/hold requests, mux feedback, status outputs).
interface loop_count_if #(
  parameter int WIDTH = 10
);
  logic             start;
  logic             hold;
  logic [WIDTH-1:0] L;
  logic             sel;
  logic [WIDTH-1:0] current_count;
  logic             busy;
  logic             loop_tick;
  logic             done;

  modport master (
    output start, hold, L,
    input  sel, current_count, busy, loop_tick, done
  );

  modport slave (
    input  start, hold, L,
    output sel, current_count, busy, loop_tick, done
  );
endinterface

// File: rtl/loop_count_ctrl.sv
// Loop-count controller: loads an initial count through the external mux,
// walks it down to zero with one tick per iteration, then pulses done.
module loop_count_ctrl #(
  parameter int WIDTH = 10
) (
  input  logic       clk,
  input  logic       rst,
  loop_count_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            count <= bus.L;
            state <= (bus.L == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          // sel=0 here, so L is the current count fed back through the mux
          if (!bus.hold) begin
            count <= bus.L - WIDTH'(1);
            if (bus.L == WIDTH'(1)) state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

  // sel is a pure state decode, which keeps the mux feedback path acyclic
  assign bus.sel           = (state != RUN);
  assign bus.busy          = (state != IDLE);
  assign bus.loop_tick     = (state == RUN) && !bus.hold;
  assign bus.done          = (state == DONE);
  assign bus.current_count = count;

endmodule
